// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, size and source types for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, MEM, RESP} arb_state_t;
  typedef enum logic {SZ4, SZ8} acc_size_t;
  typedef enum logic {SRC_IF, SRC_D} acc_src_t;
  function automatic logic [3:0] acc_bytes(acc_size_t s);
    return (s == SZ8) ? 4'd8 : 4'd4;
  endfunction
endpackage

// File: rtl/mem_range_check.sv
// mem_range_check: flags accesses whose last byte lies past the end of memory
module mem_range_check
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic [ADDR_W-1:0] addr,
  input  acc_size_t         size,
  output logic              err
);
  logic [ADDR_W:0] w_end;
  assign w_end = {1'b0, addr} + (ADDR_W+1)'(acc_bytes(size));
  assign err = w_end > (ADDR_W+1)'(MEM_BYTES);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters, one transaction at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int unsigned MEM_BYTES = 524288,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic              m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic              m_ack,
  input  logic [63:0]       m_rdata,
  output logic              busy
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  arb_state_t r_state, w_next;
  acc_src_t r_src;
  logic [SW-1:0] r_streak;
  logic w_grant_d, w_grant_if, w_any, w_err;
  logic [ADDR_W-1:0] w_addr;
  acc_size_t w_size;
  assign w_grant_d = d_req && !(if_req && r_streak == STREAK_MAX);
  assign w_grant_if = if_req && !w_grant_d;
  assign w_any = w_grant_d || w_grant_if;
  assign w_addr = w_grant_d ? d_addr : if_addr;
  assign w_size = w_grant_d ? SZ8 : SZ4;
  mem_range_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_range (
    .addr(w_addr),
    .size(w_size),
    .err (w_err)
  );
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_any ? (w_err ? RESP : MEM) : IDLE;
    else if (r_state == MEM) w_next = m_ack ? RESP : MEM;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_src    <= SRC_IF;
      r_streak <= '0;
      busy     <= 1'b0;
      if_ready <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_err   <= 1'b0;
      d_ready  <= 1'b0;
      d_valid  <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_size   <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      r_state  <= w_next;
      busy     <= w_next != IDLE;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (r_state == IDLE && w_any) begin
        if_ready <= w_grant_if;
        d_ready  <= w_grant_d;
        r_src    <= w_grant_d ? SRC_D : SRC_IF;
        r_streak <= (w_grant_d && if_req) ? ((r_streak == STREAK_MAX) ? r_streak : r_streak + SW'(1)) : '0;
        if (w_err) begin
          if_valid <= w_grant_if;
          d_valid  <= w_grant_d;
          if (w_grant_d) begin
            d_err   <= 1'b1;
            d_rdata <= '0;
          end else begin
            if_err   <= 1'b1;
            if_instr <= '0;
          end
        end else begin
          m_req   <= 1'b1;
          m_we    <= w_grant_d && d_we;
          m_size  <= w_size;
          m_addr  <= w_addr;
          m_wdata <= w_grant_d ? d_wdata : '0;
        end
      end
      if (r_state == MEM && m_ack) begin
        m_req <= 1'b0;
        if (r_src == SRC_D) begin
          d_valid <= 1'b1;
          d_err   <= 1'b0;
          d_rdata <= m_we ? '0 : m_rdata;
        end else begin
          if_valid <= 1'b1;
          if_err   <= 1'b0;
          if_instr <= m_rdata[31:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random fetch/data traffic checked against a transaction-level reference model
module tb_mem_arbiter;
  localparam longint unsigned MB = 524288;
  localparam int MAXS = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic if_req = 1'b0, if_ready, if_valid, if_err;
  logic [63:0] if_addr = '0;
  logic [31:0] if_instr;
  logic d_req = 1'b0, d_we = 1'b0, d_ready, d_valid, d_err;
  logic [63:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic m_req, m_we, m_size, m_ack = 1'b0, busy;
  logic [63:0] m_addr, m_wdata, m_rdata = '0;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(64), .MEM_BYTES(524288), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  typedef struct {
    bit is_d;
    bit we;
    bit sz8;
    bit err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;
  txn_t t;
  bit inflight = 1'b0;
  int cyc = 0, free_c = 0, ack_c = 0, val_c = 0, streak = 0, rate = 30;
  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 15))
      0: return 64'h2000;
      1: return 64'h7FFF8;
      2: return 64'h7FFF9;
      3: return 64'h7FFFC;
      4: return 64'h7FFFD;
      5: return 64'hFFFF_FFFF_FFFF_FFFE;
      6: return 64'hFFFF_FFFF_FFFF_FFF8;
      7: return 64'h100;
      8: return 64'h80000;
      default: return 64'($urandom_range(0, 524287));
    endcase
  endfunction
  // One clock of traffic: predict what the edge just passed must have produced, then drive the next inputs.
  task automatic cycle();
    bit acc, exp_mreq, exp_v;
    @(negedge clk);
    cyc++;
    acc = !inflight && cyc >= free_c && (if_req || d_req);
    if (acc) begin
      t.is_d = d_req && !(if_req && streak == MAXS);
      if (t.is_d && if_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
      else streak = 0;
      t.we = t.is_d && d_we;
      t.sz8 = t.is_d;
      t.addr = t.is_d ? d_addr : if_addr;
      t.wdata = t.is_d ? d_wdata : 64'd0;
      t.err = t.addr > MB - 64'(t.sz8 ? 8 : 4);
      t.rdata = {$urandom, $urandom};
      inflight = 1'b1;
      if (t.err) val_c = cyc;
      else begin
        ack_c = cyc + int'($urandom_range(0, 3));
        val_c = ack_c + 1;
      end
    end
    chk("if_ready", 64'(if_ready), 64'(acc && !t.is_d));
    chk("d_ready", 64'(d_ready), 64'(acc && t.is_d));
    exp_mreq = inflight && !t.err && cyc <= ack_c;
    chk("m_req", 64'(m_req), 64'(exp_mreq));
    if (exp_mreq) begin
      chk("m_we", 64'(m_we), 64'(t.we));
      chk("m_size", 64'(m_size), 64'(t.sz8));
      chk("m_addr", m_addr, t.addr);
      chk("m_wdata", m_wdata, t.wdata);
    end
    chk("busy", 64'(busy), 64'(inflight));
    exp_v = inflight && cyc == val_c;
    chk("if_valid", 64'(if_valid), 64'(exp_v && !t.is_d));
    chk("d_valid", 64'(d_valid), 64'(exp_v && t.is_d));
    if (exp_v) begin
      if (t.is_d) begin
        chk("d_err", 64'(d_err), 64'(t.err));
        chk("d_rdata", d_rdata, (t.err || t.we) ? 64'd0 : t.rdata);
      end else begin
        chk("if_err", 64'(if_err), 64'(t.err));
        if (!t.err) chk("if_instr", 64'(if_instr), 64'(t.rdata[31:0]));
      end
      inflight = 1'b0;
      free_c = cyc + 2;
    end
    m_ack = exp_mreq && cyc == ack_c;
    m_rdata = m_ack ? t.rdata : {$urandom, $urandom};
    if (if_ready) if_req = 1'b0;
    if (d_ready) d_req = 1'b0;
    if (!if_req && int'($urandom_range(0, 99)) < rate) begin
      if_req = 1'b1;
      if_addr = pick_addr();
    end
    if (!d_req && int'($urandom_range(0, 99)) < rate) begin
      d_req = 1'b1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = pick_addr();
      d_wdata = {$urandom, $urandom};
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    reset_n = 1'b1;
    rate = 35;
    repeat (600) cycle();
    rate = 100;
    repeat (200) cycle();
    rate = 70;
    for (int k = 0; k < 2000 && !(m_req && streak > 0); k++) cycle();
    m_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_m_req", 64'(m_req), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'({if_ready, d_ready}), 64'd0);
    chk("arst_valid", 64'({if_valid, d_valid}), 64'd0);
    chk("arst_m_addr", m_addr, 64'd0);
    @(negedge clk);
    chk("arst_hold_busy", 64'(busy), 64'd0);
    if_req = 1'b0;
    d_req = 1'b0;
    reset_n = 1'b1;
    inflight = 1'b0;
    streak = 0;
    free_c = 0;
    rate = 100;
    repeat (150) cycle();
    rate = 45;
    repeat (400) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the core's single unified byte-addressed memory. It shares the memory port between instruction fetch (4-byte reads) and the data path (8-byte loads/stores, including call/return stack traffic). Accepted requests are range-checked, issued one at a time to the memory with a req/ack handshake, and answered with a one-cycle response pulse. It sits between the fetch unit / ALU memory outputs and the memory array.

## Interface
- `ADDR_W`, 64: address width.
- `MEM_BYTES`, 524288: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while fetch waits.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ready`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ready`  out  1  one-cycle accept pulse for fetch.
- `if_valid`  out  1  one-cycle fetch response pulse.
- `if_instr`  out  32  instruction, little-endian; valid with `if_valid`.
- `if_err`  out  1  out-of-range fetch; valid with `if_valid`.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  64  store data.
- `d_ready`  out  1  one-cycle accept pulse for data.
- `d_valid`  out  1  one-cycle data response pulse (loads and stores).
- `d_rdata`  out  64  load data; 0 for stores and errors.
- `d_err`  out  1  out-of-range data access.
- `m_req`  out  1  memory request; held until `m_ack`.
- `m_we`  out  1  memory write.
- `m_size`  out  1  0 = 4 bytes, 1 = 8 bytes.
- `m_addr`  out  ADDR_W  memory byte address.
- `m_wdata`  out  64  memory write data.
- `m_ack`  in  1  memory completion, sampled while `m_req` = 1.
- `m_rdata`  in  64  read data, valid with `m_ack`; bits 31:0 carry 4-byte reads.
- `busy`  out  1  state is not IDLE.

## Operation
- States are IDLE, MEM and RESP. Only one transaction is in flight.
- **IDLE.** Arbitrate among asserted requests.
  - Data wins unless `if_req`=1 and streak = MAX_DATA_STREAK; then fetch wins.
  - Winner is latched (address, we, wdata, size, source) and its `*_ready` pulses.
  - Range check at accept: error if addr + size > MEM_BYTES. The sum is computed ADDR_W+1 bits wide so wrap-around is an error.
  - Error: go to RESP with err=1 and no memory access. Otherwise go to MEM.
- **MEM.** `m_req`=1 with the latched fields.
  - On `m_ack`, capture `m_rdata` (zero-extend for fetch, 0 for stores) and go to RESP.
  - No timeout; the memory must eventually ack.
- **RESP.** Pulse `*_valid` for the latched source, with data and err. Go to IDLE.
- **Streak counter.**
  - Increments on a data grant while `if_req`=1, saturating at MAX_DATA_STREAK.
  - Clears on a fetch grant, and on a data grant while `if_req`=0.
- **Registered outputs.** All outputs are registered. `m_*` fields and response data hold their last values between transactions. `*_ready` and `*_valid` are single-cycle pulses.
- **Reset.** Asynchronous assertion (`reset_n`=0) clears every output and register to 0 and forces IDLE.
  - This includes mid-transaction: `m_req` drops immediately and no response is produced.
  - Release is synchronised by the surrounding design; the first arbitration happens at the first rising edge with `reset_n`=1.

## Timing
- Accept at edge N (`*_ready` high in cycle N+1).
- `m_req` high in cycle N+1.
- With `m_ack` high in that cycle: `*_valid` in cycle N+2, IDLE again in N+3.
- Minimum request-to-request spacing: 3 cycles. Each memory wait cycle adds 1.
- Error path: `*_valid` with err in cycle N+1 after accept; 2-cycle spacing.
- Requests deasserted before `*_ready` are dropped silently; the arbiter does not latch them.
- A requester may raise a new request in the same cycle its `*_valid` is high.

## Structure
- Package `mem_arbiter_pkg`: state enum `arb_state_t` {IDLE, MEM, RESP}, size enum `acc_size_t` {SZ4, SZ8}, and a source enum {SRC_IF, SRC_D}.
- One sub-module, `mem_range_check` (combinational): inputs addr, size, MEM_BYTES; output err.

## Test plan
- Fetch of `if_addr`=0x2000, memory returns 0x11223344 with zero wait: `if_ready` in cycle 1, `m_size`=0, `if_valid` in cycle 2, `if_instr`=0x11223344, `if_err`=0.
- Simultaneous `if_req` and `d_req` (load at 0x7FFF8, 2 wait cycles): data granted first, `d_rdata`=`m_rdata`; fetch granted at the next IDLE.
- `d_req` held continuously with `if_req`: exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- Store to 0x7FFF9 (8 bytes, exceeds 524288): `d_valid`=1 with `d_err`=1 one cycle after accept; `m_req` never asserts. Fetch at 0xFFFF_FFFF_FFFF_FFFE also errors.
- `reset_n` pulled low while in MEM: `m_req`, `busy` and all pulses go to 0 immediately; after release, state is IDLE and streak is 0.
- Store of 0xDEADBEEF_CAFEF00D to 0x100: `m_we`=1, `m_size`=1, `m_wdata` matches; `d_valid` with `d_rdata`=0.
